alu_issue_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/alu_issue_decode.sv | 115 +++++++++++
 rtl/alu_issue_unit.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue path: ALU control codes,
// RV64 opcode / funct3 / funct7 encodings, operation classes and the
// branch-condition helper used when resolving a branch from ALU flags.
package alu_pkg;

    localparam int DEF_XLEN    = 64;
    localparam int DEF_SHAMT_W = 6;

    // ALU control codes understood by the combinational ALU.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    // Major opcodes handled by this unit.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 for integer ALU ops.
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for branches.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // How the result stage turns ALU outputs into the final result.
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,   // result is alu_y verbatim
        CLS_SLT     = 3'd1,   // result is signed-less flag
        CLS_SLTU    = 3'd2,   // result is unsigned-less flag
        CLS_BRANCH  = 3'd3,   // result 0, branch condition from flags
        CLS_ILLEGAL = 3'd4    // result 0, illegal flagged
    } op_class_e;

    // Branch resolution from the flags of a SUB of rs1/rs2.
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       s_less,
                                         input logic       u_less);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = s_less;
            F3_BGE:  taken = !s_less;
            F3_BLTU: taken = u_less;
            F3_BGEU: taken = !u_less;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Purpose : combinational decode of an instruction + operands into ALU control,
//           ALU operands, result class and illegal flag.
// Latency : 0 cycles (pure combinational). Backpressure: none, no state.
// Ports   : instr/rs1_data/rs2_data/imm/pc in; control/a1/a2/op_class/illegal out.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [3:0]      control,
    output logic [XLEN-1:0] a1,
    output logic [XLEN-1:0] a2,
    output op_class_e       op_class,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            is_r;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] shamt_ext;

    // Register specifiers and rd are resolved elsewhere in the core.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign is_r = (opcode == OPC_OP);
    assign src2 = is_r ? rs2_data : imm;

    // Shift amounts forward only the low bits; upper source bits never reach the ALU.
    assign shamt_ext = {{(XLEN-SHAMT_W){1'b0}}, src2[SHAMT_W-1:0]};

    always_comb begin
        // Illegal encoding is the fallback: add with zero operands.
        control  = ALU_ADD;
        a1       = '0;
        a2       = '0;
        op_class = CLS_ILLEGAL;
        illegal  = 1'b1;

        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                if (!is_r || funct7 == F7_BASE || funct7 == F7_ALT) begin
                    illegal  = 1'b0;
                    op_class = CLS_ALU;
                    a1       = rs1_data;
                    a2       = src2;
                    case (funct3)
                        F3_ADD:  control = (is_r && instr[30]) ? ALU_SUB : ALU_ADD;
                        F3_XOR:  control = ALU_XOR;
                        F3_OR:   control = ALU_OR;
                        F3_AND:  control = ALU_AND;
                        F3_SLL: begin
                            control = ALU_SLL;
                            a2      = shamt_ext;
                        end
                        F3_SR: begin
                            control = instr[30] ? ALU_SRA : ALU_SRL;
                            a2      = shamt_ext;
                        end
                        // Compares run as a SUB; the result stage picks the flag.
                        F3_SLT: begin
                            control  = ALU_SUB;
                            op_class = CLS_SLT;
                        end
                        F3_SLTU: begin
                            control  = ALU_SUB;
                            op_class = CLS_SLTU;
                        end
                        default: ;
                    endcase
                end
            end
            OPC_LOAD, OPC_STORE: begin
                illegal  = 1'b0;
                op_class = CLS_ALU;
                a1       = rs1_data;
                a2       = imm;
            end
            OPC_LUI: begin
                illegal  = 1'b0;
                op_class = CLS_ALU;
                a2       = imm;
            end
            OPC_AUIPC: begin
                illegal  = 1'b0;
                op_class = CLS_ALU;
                a1       = pc;
                a2       = imm;
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    illegal  = 1'b0;
                    op_class = CLS_BRANCH;
                    control  = ALU_SUB;
                    a1       = rs1_data;
                    a2       = rs2_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Purpose : issue side of the ALU: decode -> D register drives ALU -> R register holds result.
// Latency : 2 cycles accept-to-out_valid, 1 request/cycle throughput.
// Backpressure: out_valid && !out_ready freezes R and D; in_ready drops once D is also full.
// Ports   : in_* request handshake + operands; alu_* ALU drive/return; out_*/result/
//           branch_taken/illegal result handshake.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] alu_a1,
    output logic [XLEN-1:0] alu_a2,
    input  logic [XLEN-1:0] alu_y,
    input  logic            alu_zero,
    input  logic            alu_s_less,
    input  logic            alu_u_less,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            illegal
);

    // Decode outputs
    logic [3:0]      dec_control;
    logic [XLEN-1:0] dec_a1;
    logic [XLEN-1:0] dec_a2;
    op_class_e       dec_class;
    logic            dec_illegal;

    // Stage D
    logic            d_valid_q,   d_valid_d;
    logic [3:0]      d_control_q, d_control_d;
    logic [XLEN-1:0] d_a1_q,      d_a1_d;
    logic [XLEN-1:0] d_a2_q,      d_a2_d;
    op_class_e       d_class_q,   d_class_d;
    logic [2:0]      d_funct3_q,  d_funct3_d;

    // Stage R
    logic            r_valid_q,   r_valid_d;
    logic [XLEN-1:0] r_result_q,  r_result_d;
    logic            r_taken_q,   r_taken_d;
    logic            r_illegal_q, r_illegal_d;

    logic            advance;
    logic            accept;
    logic [XLEN-1:0] form_result;
    logic            form_taken;
    logic            form_illegal;

    alu_issue_decode #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .imm      (imm),
        .pc       (pc),
        .control  (dec_control),
        .a1       (dec_a1),
        .a2       (dec_a2),
        .op_class (dec_class),
        .illegal  (dec_illegal)
    );

    // R can take a new entry when empty or when its entry leaves this cycle.
    assign advance  = !r_valid_q || out_ready;
    // D accepts when empty even if R is stalled; in_ready is held low during reset.
    assign in_ready = !rst && (!d_valid_q || advance);
    assign accept   = in_valid && in_ready;

    // Result formation from the ALU outputs of the entry sitting in D.
    always_comb begin
        form_result  = '0;
        form_taken   = 1'b0;
        form_illegal = 1'b0;
        case (d_class_q)
            CLS_ALU:     form_result = alu_y;
            CLS_SLT:     form_result = {{(XLEN-1){1'b0}}, alu_s_less};
            CLS_SLTU:    form_result = {{(XLEN-1){1'b0}}, alu_u_less};
            CLS_BRANCH:  form_taken  = branch_cond(d_funct3_q, alu_zero, alu_s_less, alu_u_less);
            CLS_ILLEGAL: form_illegal = 1'b1;
            default:     form_illegal = 1'b1;
        endcase
    end

    always_comb begin
        d_valid_d   = d_valid_q;
        d_control_d = d_control_q;
        d_a1_d      = d_a1_q;
        d_a2_d      = d_a2_q;
        d_class_d   = d_class_q;
        d_funct3_d  = d_funct3_q;
        r_valid_d   = r_valid_q;
        r_result_d  = r_result_q;
        r_taken_d   = r_taken_q;
        r_illegal_d = r_illegal_q;

        if (advance) begin
            r_valid_d = d_valid_q;
            // An empty slot moving into R carries zeros so no stale result lingers.
            r_result_d  = d_valid_q ? form_result  : '0;
            r_taken_d   = d_valid_q && form_taken;
            r_illegal_d = d_valid_q && form_illegal;
            d_valid_d   = 1'b0;
        end

        if (accept) begin
            d_valid_d   = 1'b1;
            d_control_d = dec_control;
            d_a1_d      = dec_a1;
            d_a2_d      = dec_a2;
            d_class_d   = dec_class;
            d_funct3_d  = instr[14:12];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q   <= 1'b0;
            d_control_q <= ALU_ADD;
            d_a1_q      <= '0;
            d_a2_q      <= '0;
            d_class_q   <= CLS_ALU;
            d_funct3_q  <= '0;
            r_valid_q   <= 1'b0;
            r_result_q  <= '0;
            r_taken_q   <= 1'b0;
            r_illegal_q <= 1'b0;
        end else begin
            d_valid_q   <= d_valid_d;
            d_control_q <= d_control_d;
            d_a1_q      <= d_a1_d;
            d_a2_q      <= d_a2_d;
            d_class_q   <= d_class_d;
            d_funct3_q  <= d_funct3_d;
            r_valid_q   <= r_valid_d;
            r_result_q  <= r_result_d;
            r_taken_q   <= r_taken_d;
            r_illegal_q <= r_illegal_d;
        end
    end

    assign alu_control  = d_control_q;
    assign alu_a1       = d_a1_q;
    assign alu_a2       = d_a2_q;
    assign out_valid    = r_valid_q;
    assign result       = r_result_q;
    assign branch_taken = r_taken_q;
    assign illegal      = r_illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU model on the alu_* ports, directed
// cases plus a randomized stream scored against an instruction-level model.
module tb_alu_issue_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data, rs2_data, imm, pc;
    logic [3:0]  alu_control;
    logic [63:0] alu_a1, alu_a2, alu_y;
    logic        alu_zero, alu_s_less, alu_u_less;
    logic        out_valid, out_ready;
    logic [63:0] result;
    logic        branch_taken, illegal;

    alu_issue_unit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .pc           (pc),
        .alu_control  (alu_control),
        .alu_a1       (alu_a1),
        .alu_a2       (alu_a2),
        .alu_y        (alu_y),
        .alu_zero     (alu_zero),
        .alu_s_less   (alu_s_less),
        .alu_u_less   (alu_u_less),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU as seen by the issue unit.
    always_comb begin
        case (alu_control)
            4'b0010: alu_y = alu_a1 + alu_a2;
            4'b0110: alu_y = alu_a1 - alu_a2;
            4'b0111: alu_y = alu_a1 ^ alu_a2;
            4'b0001: alu_y = alu_a1 | alu_a2;
            4'b0000: alu_y = alu_a1 & alu_a2;
            4'b0011: alu_y = alu_a1 << alu_a2[5:0];
            4'b1000: alu_y = alu_a1 >> alu_a2[5:0];
            4'b1010: alu_y = 64'($signed(alu_a1) >>> alu_a2[5:0]);
            default: alu_y = 64'd0;
        endcase
        alu_zero   = (alu_y == 64'd0);
        alu_s_less = ($signed(alu_a1) < $signed(alu_a2));
        alu_u_less = (alu_a1 < alu_a2);
    end

    typedef struct packed {
        logic [63:0] res;
        logic        tk;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_pop = 0;
    int          n_push = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] prev_res;
    logic        prev_tk, prev_ill;
    logic [63:0] last_res;
    logic        last_tk, last_ill;
    logic        last_accept = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7);
        return {f7, 10'd0, f3, 5'd0, opc};
    endfunction

    // Instruction-level reference: what the instruction means, not how the pipe computes it.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a,
                                   input logic [63:0] b, input logic [63:0] im,
                                   input logic [63:0] p);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] src;
        logic        is_r;
        e   = '0;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        case (opc)
            7'b0110011, 7'b0010011: begin
                is_r = (opc == 7'b0110011);
                src  = is_r ? b : im;
                if (is_r && f7 != 7'h00 && f7 != 7'h20) e.ill = 1'b1;
                else begin
                    case (f3)
                        3'd0: e.res = (is_r && ins[30]) ? a - src : a + src;
                        3'd1: e.res = a << src[5:0];
                        3'd2: e.res = ($signed(a) < $signed(src)) ? 64'd1 : 64'd0;
                        3'd3: e.res = (a < src) ? 64'd1 : 64'd0;
                        3'd4: e.res = a ^ src;
                        3'd5: e.res = ins[30] ? 64'($signed(a) >>> src[5:0]) : a >> src[5:0];
                        3'd6: e.res = a | src;
                        default: e.res = a & src;
                    endcase
                end
            end
            7'b0000011, 7'b0100011: e.res = a + im;
            7'b0110111:             e.res = im;
            7'b0010111:             e.res = p + im;
            7'b1100011: begin
                case (f3)
                    3'd0: e.tk = (a == b);
                    3'd1: e.tk = (a != b);
                    3'd4: e.tk = ($signed(a) < $signed(b));
                    3'd5: e.tk = ($signed(a) >= $signed(b));
                    3'd6: e.tk = (a < b);
                    3'd7: e.tk = (a >= b);
                    default: e.ill = 1'b1;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // One cycle: sample handshakes #1 after the falling edge, then wait for the next one.
    task automatic step();
        exp_t e;
        #1;
        if (stall_prev) begin
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_result", result, prev_res);
            check_eq("hold_taken", 64'(branch_taken), 64'(prev_tk));
            check_eq("hold_illegal", 64'(illegal), 64'(prev_ill));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_result", result, e.res);
                check_eq("sb_taken", 64'(branch_taken), 64'(e.tk));
                check_eq("sb_illegal", 64'(illegal), 64'(e.ill));
                last_res = result;
                last_tk  = branch_taken;
                last_ill = illegal;
                n_pop++;
            end
        end
        stall_prev  = out_valid && !out_ready;
        prev_res    = result;
        prev_tk     = branch_taken;
        prev_ill    = illegal;
        last_accept = in_valid && in_ready;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(instr, rs1_data, rs2_data, imm, pc));
            n_push++;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic [63:0] p);
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
        pc       = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_pop(input string tag, output int lat);
        int base;
        base = n_pop;
        lat  = 0;
        while (n_pop == base && lat < 8) begin
            step();
            lat++;
        end
        check_eq({tag, "_arrived"}, 64'(n_pop - base), 64'd1);
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 64'($urandom_range(0, 8));
            1:       return -64'($urandom_range(0, 8));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic gen_req();
        logic [31:0] ins;
        logic [6:0]  opc;
        int          pick;
        ins  = $urandom;
        pick = $urandom_range(0, 9);
        if (pick <= 3) begin
            opc = 7'b0110011;
            if ($urandom_range(0, 7) != 0) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end else if (pick <= 5) begin
            opc = 7'b0010011;
            if (ins[13:12] == 2'b01) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        end else if (pick == 6) opc = $urandom_range(0, 1) ? 7'b0000011 : 7'b0100011;
        else if (pick == 7)     opc = $urandom_range(0, 1) ? 7'b0110111 : 7'b0010111;
        else if (pick == 8)     opc = 7'b1100011;
        else                    opc = 7'($urandom);
        ins[6:0] = opc;
        instr    = ins;
        rs1_data = rnd_op();
        rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : rnd_op();
        pc       = {$urandom, $urandom};
        if (opc == 7'b0010011 || opc == 7'b0000011) imm = {{52{ins[31]}}, ins[31:20]};
        else imm = rnd_op();
    endtask

    int lat;
    int base_push, base_pop;
    logic saw_low;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_taken", 64'(branch_taken), 64'd0);
        check_eq("rst_illegal", 64'(illegal), 64'd0);
        check_eq("rst_a1", alu_a1, 64'd0);
        check_eq("rst_a2", alu_a2, 64'd0);
        check_eq("rst_control", 64'(alu_control), 64'h2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // R-type sub 5-7
        issue(mk(7'b0110011, 3'b000, 7'h20), 64'd5, 64'd7, 64'd0, 64'd0);
        check_eq("sub_control", 64'(alu_control), 64'h6);
        wait_pop("sub", lat);
        check_eq("sub_latency", 64'(lat), 64'd2);
        check_eq("sub_result", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("sub_illegal", 64'(last_ill), 64'd0);

        // slli: only imm[5:0] is forwarded
        issue(mk(7'b0010011, 3'b001, 7'h00), 64'd1, 64'd0, 64'h41, 64'd0);
        check_eq("slli_a2", alu_a2, 64'd1);
        wait_pop("slli", lat);
        check_eq("slli_result", last_res, 64'd2);

        // srai
        issue(mk(7'b0010011, 3'b101, 7'h20), 64'h8000_0000_0000_0000, 64'd0, 64'h404, 64'd0);
        check_eq("srai_control", 64'(alu_control), 64'hA);
        wait_pop("srai", lat);
        check_eq("srai_result", last_res, 64'hF800_0000_0000_0000);

        // Branches
        issue(mk(7'b1100011, 3'b100, 7'h00), -64'd1, 64'd1, 64'd0, 64'd0);
        wait_pop("blt", lat);
        check_eq("blt_taken", 64'(last_tk), 64'd1);
        check_eq("blt_result", last_res, 64'd0);
        issue(mk(7'b1100011, 3'b110, 7'h00), -64'd1, 64'd1, 64'd0, 64'd0);
        wait_pop("bltu", lat);
        check_eq("bltu_taken", 64'(last_tk), 64'd0);
        issue(mk(7'b1100011, 3'b000, 7'h00), 64'd3, 64'd3, 64'd0, 64'd0);
        wait_pop("beq", lat);
        check_eq("beq_taken", 64'(last_tk), 64'd1);
        issue(mk(7'b1100011, 3'b010, 7'h00), 64'd3, 64'd3, 64'd0, 64'd0);
        wait_pop("br010", lat);
        check_eq("br010_illegal", 64'(last_ill), 64'd1);
        check_eq("br010_taken", 64'(last_tk), 64'd0);

        // AUIPC and W-op
        issue(mk(7'b0010111, 3'b000, 7'h00), 64'd0, 64'd0, 64'h2000, 64'h1000);
        wait_pop("auipc", lat);
        check_eq("auipc_result", last_res, 64'h3000);
        issue(mk(7'b0111011, 3'b000, 7'h00), 64'd9, 64'd4, 64'd0, 64'd0);
        check_eq("wop_a1", alu_a1, 64'd0);
        wait_pop("wop", lat);
        check_eq("wop_illegal", 64'(last_ill), 64'd1);
        check_eq("wop_result", last_res, 64'd0);

        // Backpressure: 4 back-to-back addi, consumer stalls 3 cycles after first result
        base_push = n_push;
        base_pop  = n_pop;
        saw_low   = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (n_push - base_push < 4) begin
                in_valid = 1'b1;
                instr    = mk(7'b0010011, 3'b000, 7'h00);
                rs1_data = 64'(100 * (n_push - base_push + 1));
                imm      = 64'(n_push - base_push);
            end else in_valid = 1'b0;
            out_ready = !(c >= 2 && c <= 4);
            #1;
            if (!in_ready) saw_low = 1'b1;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_eq("bp_in_ready_dropped", 64'(saw_low), 64'd1);
        check_eq("bp_pushed", 64'(n_push - base_push), 64'd4);
        check_eq("bp_popped", 64'(n_pop - base_pop), 64'd4);

        // Reset with both stages occupied
        out_ready = 1'b0;
        issue(mk(7'b0110011, 3'b000, 7'h00), 64'd1, 64'd2, 64'd0, 64'd0);
        issue(mk(7'b0110011, 3'b000, 7'h00), 64'd3, 64'd4, 64'd0, 64'd0);
        check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_result", result, 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("mid_rst_control", 64'(alu_control), 64'h2);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        base_pop = n_pop;
        repeat (4) step();
        check_eq("post_rst_no_output", 64'(n_pop - base_pop), 64'd0);
        check_eq("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Randomized stream with random backpressure
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_accept) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid) gen_req();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
